// File: rtl/iob_eth_pkg.sv
// Shared constants for the Ethernet core CPU-side register map and the TX DMA FSM.
package iob_eth_pkg;

  // Core register map (word addresses on the CPU-side slave port)
  localparam int unsigned EthStatusAddr   = 0;
  localparam int unsigned EthSendAddr     = 1;
  localparam int unsigned EthRcvackAddr   = 2;
  localparam int unsigned EthSoftrstAddr  = 3;
  localparam int unsigned EthDummyAddr    = 4;
  localparam int unsigned EthTxNbytesAddr = 5;
  localparam int unsigned EthRxNbytesAddr = 6;
  localparam int unsigned EthCrcAddr      = 7;
  localparam int unsigned EthDataBase     = 2048;

  // STATUS register bit positions
  localparam int unsigned EthStatusTxReady = 0;
  localparam int unsigned EthStatusRxReady = 1;

  // TX DMA state encoding
  localparam int unsigned TxStateW = 3;
  localparam logic [TxStateW-1:0] StIdle   = 3'd0;
  localparam logic [TxStateW-1:0] StPoll   = 3'd1;
  localparam logic [TxStateW-1:0] StLoad   = 3'd2;
  localparam logic [TxStateW-1:0] StDrop   = 3'd3;
  localparam logic [TxStateW-1:0] StPad    = 3'd4;
  localparam logic [TxStateW-1:0] StNbytes = 3'd5;
  localparam logic [TxStateW-1:0] StSend   = 3'd6;

endpackage

// File: rtl/iob_eth_bus_master.sv
// Single-outstanding-transaction master for the core's CPU-side slave port.
// A request is taken only while the bus is idle; after a completion m_valid
// is low for at least one cycle, so the slave's registered ready is never reused.
module iob_eth_bus_master #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_wstrb,
  input  logic [31:0]       req_wdata,
  output logic              idle,
  output logic              cpl,
  output logic [31:0]       cpl_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_wstrb,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;

  assign idle      = ~valid_q;
  assign cpl       = valid_q & m_ready;
  assign cpl_rdata = m_rdata;
  assign m_valid   = valid_q;
  assign m_addr    = addr_q;
  assign m_wstrb   = wstrb_q;
  assign m_wdata   = wdata_q;

  // Launch on request when idle, drop valid on completion; payload frozen while valid
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    if (valid_q) begin
      if (m_ready) valid_d = 1'b0;
    end else if (req) begin
      valid_d = 1'b1;
      addr_d  = req_addr;
      wstrb_d = req_wstrb;
      wdata_d = req_wdata;
    end
  end

  // Request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: rtl/iob_eth_tx_dma.sv
// Stream-to-bus loader: polls STATUS, copies a frame into the TX buffer,
// zero-pads short frames, then writes TX_NBYTES and SEND.
module iob_eth_tx_dma
  import iob_eth_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned MAX_BYTES    = 1518,
  parameter int unsigned MIN_BYTES    = 46,
  parameter int unsigned STATUS_ADDR  = EthStatusAddr,
  parameter int unsigned SEND_ADDR    = EthSendAddr,
  parameter int unsigned NBYTES_ADDR  = EthTxNbytesAddr,
  parameter int unsigned DATA_BASE    = EthDataBase,
  parameter int unsigned POLL_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_wstrb,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int unsigned PollW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_TIMEOUT - 1);
  localparam logic [10:0] MaxB = 11'(MAX_BYTES);
  localparam logic [10:0] MinB = 11'(MIN_BYTES);

  logic [TxStateW-1:0] state_q, state_d;
  logic [10:0]         idx_q, idx_d;
  logic [10:0]         n_q, n_d;
  logic [PollW-1:0]    poll_q, poll_d;
  // Set while the in-flight transaction was issued by POLL/NBYTES/SEND, so a
  // trailing data write completing after a state change is not mistaken for it.
  logic                own_q, own_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                tmo_q, tmo_d;

  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_wstrb;
  logic [31:0]       req_wdata;
  logic              bm_idle;
  logic              bm_cpl;
  logic [31:0]       bm_rdata;
  logic              unused_rdata;

  logic [10:0]       idx_inc;
  logic [ADDR_W-1:0] data_addr;

  assign idx_inc      = idx_q + 11'd1;
  assign data_addr    = ADDR_W'(DATA_BASE) + ADDR_W'(idx_q);
  assign unused_rdata = ^bm_rdata;

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err_overflow = ovf_q;
  assign err_timeout  = tmo_q;

  iob_eth_bus_master #(
    .ADDR_W(ADDR_W)
  ) u_bus_master (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_wstrb(req_wstrb),
    .req_wdata(req_wdata),
    .idle     (bm_idle),
    .cpl      (bm_cpl),
    .cpl_rdata(bm_rdata),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_wstrb  (m_wstrb),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready)
  );

  // Next-state, bus request and stream handshake decode
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    poll_d    = poll_q;
    own_d     = own_q;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    tmo_d     = 1'b0;
    req       = 1'b0;
    req_addr  = '0;
    req_wstrb = '0;
    req_wdata = '0;
    s_ready   = 1'b0;
    if (bm_cpl) own_d = 1'b0;

    case (state_q)
      StIdle: begin
        idx_d  = '0;
        n_d    = '0;
        poll_d = '0;
        if (s_valid) state_d = StPoll;
      end

      StPoll: begin
        if (poll_q == PollLast) begin
          poll_d = '0;
          tmo_d  = 1'b1;
        end else begin
          poll_d = poll_q + PollW'(1);
        end
        if (bm_idle) begin
          req      = 1'b1;
          req_addr = ADDR_W'(STATUS_ADDR);
          own_d    = 1'b1;
        end else if (bm_cpl && own_q && bm_rdata[EthStatusTxReady]) begin
          poll_d  = '0;
          tmo_d   = 1'b0;
          state_d = StLoad;
        end
      end

      StLoad: begin
        // Ready only while the bus is free, so each accept is a single cycle
        s_ready = bm_idle;
        if (bm_idle && s_valid) begin
          req       = 1'b1;
          req_addr  = data_addr;
          req_wstrb = 4'b0001;
          req_wdata = {24'b0, s_data};
          idx_d     = idx_inc;
          if (s_last) begin
            n_d     = idx_inc;
            state_d = (idx_inc < MinB) ? StPad : StNbytes;
          end else if (idx_inc == MaxB) begin
            state_d = StDrop;
          end
        end
      end

      StDrop: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          ovf_d   = 1'b1;
          state_d = StIdle;
        end
      end

      StPad: begin
        if (bm_idle) begin
          req       = 1'b1;
          req_addr  = data_addr;
          req_wstrb = 4'b0001;
          req_wdata = '0;
          idx_d     = idx_inc;
          if (idx_inc >= MinB) begin
            n_d     = MinB;
            state_d = StNbytes;
          end
        end
      end

      StNbytes: begin
        if (bm_idle) begin
          req       = 1'b1;
          req_addr  = ADDR_W'(NBYTES_ADDR);
          req_wstrb = 4'b1111;
          req_wdata = {21'b0, n_q};
          own_d     = 1'b1;
        end else if (bm_cpl && own_q) begin
          state_d = StSend;
        end
      end

      StSend: begin
        if (bm_idle) begin
          req       = 1'b1;
          req_addr  = ADDR_W'(SEND_ADDR);
          req_wstrb = 4'b1111;
          req_wdata = 32'd1;
          own_d     = 1'b1;
        end else if (bm_cpl && own_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // FSM state, counters and registered event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      n_q     <= '0;
      poll_q  <= '0;
      own_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      poll_q  <= poll_d;
      own_q   <= own_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_iob_eth_tx_dma.sv
// Self-checking bench for iob_eth_tx_dma: expected bus writes are queued as
// bytes are driven and compared as the slave model sees each write complete.
module tb_iob_eth_tx_dma;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned MAX_BYTES = 1518;
  localparam int unsigned MIN_BYTES = 46;
  localparam int unsigned POLL_TO   = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_last, s_ready;
  logic [7:0]        s_data;
  logic              m_valid, m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_wstrb;
  logic [31:0]       m_wdata, m_rdata;
  logic              busy, done, err_overflow, err_timeout;

  logic force_rdy;
  logic status_rdy;

  int checks = 0;
  int errors = 0;

  logic [47:0] sb[$];

  always #5 clk = ~clk;

  iob_eth_tx_dma #(
    .ADDR_W      (ADDR_W),
    .MAX_BYTES   (MAX_BYTES),
    .MIN_BYTES   (MIN_BYTES),
    .STATUS_ADDR (0),
    .SEND_ADDR   (1),
    .NBYTES_ADDR (5),
    .DATA_BASE   (2048),
    .POLL_TIMEOUT(POLL_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_addr      (m_addr),
    .m_wstrb     (m_wstrb),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .busy        (busy),
    .done        (done),
    .err_overflow(err_overflow),
    .err_timeout (err_timeout)
  );

  // Slave model: ready is a registered copy of valid (optionally forced high)
  always @(posedge clk or posedge rst) begin
    if (rst) m_ready <= 1'b0;
    else     m_ready <= m_valid | force_rdy;
  end
  assign m_rdata = (m_addr == 12'd0) ? {31'b0, status_rdy} : 32'h0;

  logic [47:0] bus_now;
  logic [53:0] outs;
  assign bus_now = {m_addr, m_wstrb, m_wdata};
  assign outs = {s_ready, m_valid, m_addr, m_wstrb, m_wdata, busy, done, err_overflow, err_timeout};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, ovf_cnt = 0, tmo_cnt = 0;
  int gap_viol = 0, len_viol = 0, stab_viol = 0, rdaddr_viol = 0, early_rdy = 0;
  int vrun = 0;
  logic prev_cpl = 1'b0, prev_valid = 1'b0;
  logic [47:0] prev_bus = '0;

  always @(negedge clk) begin
    if (rst) begin
      vrun       <= 0;
      prev_cpl   <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        if (vrun != 1) len_viol <= len_viol + 1;
        if (m_wstrb == 4'b0) begin
          rd_cnt <= rd_cnt + 1;
          if (m_addr != 12'd0) rdaddr_viol <= rdaddr_viol + 1;
        end else begin
          logic [47:0] exp_w;
          exp_w = (sb.size() != 0) ? sb.pop_front() : '1;
          wr_cnt <= wr_cnt + 1;
          check_eq("bus_wr", 64'(bus_now), 64'(exp_w));
        end
      end
      if (prev_cpl && m_valid) gap_viol <= gap_viol + 1;
      if (prev_valid && m_valid && bus_now != prev_bus) stab_viol <= stab_viol + 1;
      if (s_ready && !status_rdy) early_rdy <= early_rdy + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (err_overflow) ovf_cnt <= ovf_cnt + 1;
      if (err_timeout) tmo_cnt <= tmo_cnt + 1;
      vrun       <= m_valid ? vrun + 1 : 0;
      prev_cpl   <= m_valid & m_ready;
      prev_valid <= m_valid;
      prev_bus   <= bus_now;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    n = 0;
    #1;
    while (!s_ready && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) check_eq("sready_timeout", 64'(n), 64'd0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Drives nsend bytes of a len-byte frame, queueing the writes it should cause
  task automatic send_frame(input int len, input int nsend, input logic [7:0] off);
    for (int i = 0; i < nsend; i++) begin
      logic [7:0] b;
      b = off + 8'(i);
      if (i < MAX_BYTES) sb.push_back({12'(2048 + i), 4'b0001, 24'h0, b});
      send_byte(b, (i == len - 1));
    end
    if (nsend == len && len <= MAX_BYTES) begin
      for (int i = len; i < MIN_BYTES; i++) sb.push_back({12'(2048 + i), 4'b0001, 32'h0});
      sb.push_back({12'd5, 4'hF, 32'((len < MIN_BYTES) ? MIN_BYTES : len)});
      sb.push_back({12'd1, 4'hF, 32'd1});
    end
  endtask

  task automatic wait_end(input int d0, input int o0);
    int n;
    n = 0;
    while (done_cnt == d0 && ovf_cnt == o0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("wait_end_timeout", 64'(n), 64'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int d0, o0, w0, t0, r0, c0;
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = 8'h0;
    s_last     = 1'b0;
    force_rdy  = 1'b0;
    status_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_out", 64'(outs), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_out", 64'(outs), 64'd0);

    // 60-byte frame, no padding
    d0 = done_cnt; o0 = ovf_cnt; w0 = wr_cnt;
    send_frame(60, 60, 8'h00);
    wait_end(d0, o0);
    check_eq("f60_done", 64'(done_cnt - d0), 64'd1);
    check_eq("f60_writes", 64'(wr_cnt - w0), 64'd62);
    check_eq("f60_sb_left", 64'(sb.size()), 64'd0);
    check_eq("f60_busy", 64'(busy), 64'd0);

    // 10-byte frame padded to minimum
    d0 = done_cnt; o0 = ovf_cnt; w0 = wr_cnt;
    send_frame(10, 10, 8'h80);
    wait_end(d0, o0);
    check_eq("f10_done", 64'(done_cnt - d0), 64'd1);
    check_eq("f10_writes", 64'(wr_cnt - w0), 64'd48);
    check_eq("f10_sb_left", 64'(sb.size()), 64'd0);

    // Transmitter not ready for 300 STATUS reads
    d0 = done_cnt; o0 = ovf_cnt; t0 = tmo_cnt; r0 = rd_cnt;
    status_rdy = 1'b0;
    fork
      send_frame(20, 20, 8'h20);
      begin
        int n;
        n = 0;
        while ((rd_cnt - r0) < 300 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        status_rdy = 1'b1;
      end
    join
    wait_end(d0, o0);
    check_eq("poll_timeouts", 64'(tmo_cnt - t0), 64'd9);
    check_eq("poll_reads", 64'(rd_cnt - r0), 64'd301);
    check_eq("poll_early_ready", 64'(early_rdy), 64'd0);
    check_eq("poll_done", 64'(done_cnt - d0), 64'd1);
    check_eq("poll_sb_left", 64'(sb.size()), 64'd0);

    // Oversized frame is loaded up to MAX_BYTES, then drained and dropped
    d0 = done_cnt; o0 = ovf_cnt; w0 = wr_cnt;
    send_frame(1600, 1600, 8'h11);
    wait_end(d0, o0);
    check_eq("ovf_pulse", 64'(ovf_cnt - o0), 64'd1);
    check_eq("ovf_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("ovf_writes", 64'(wr_cnt - w0), 64'(MAX_BYTES));
    check_eq("ovf_sb_left", 64'(sb.size()), 64'd0);
    check_eq("ovf_busy", 64'(busy), 64'd0);

    // Exactly MAX_BYTES with last on the final byte is sent
    d0 = done_cnt; o0 = ovf_cnt; w0 = wr_cnt;
    send_frame(MAX_BYTES, MAX_BYTES, 8'h3C);
    wait_end(d0, o0);
    check_eq("max_done", 64'(done_cnt - d0), 64'd1);
    check_eq("max_no_ovf", 64'(ovf_cnt - o0), 64'd0);
    check_eq("max_writes", 64'(wr_cnt - w0), 64'(MAX_BYTES + 2));

    // Reset after 20 bytes of a frame, then a fresh frame
    d0 = done_cnt; w0 = wr_cnt;
    send_frame(30, 20, 8'h55);
    repeat (4) @(negedge clk);
    check_eq("stall_busy", 64'(busy), 64'd1);
    check_eq("stall_writes", 64'(wr_cnt - w0), 64'd20);
    check_eq("stall_sb_left", 64'(sb.size()), 64'd0);
    #2 rst = 1'b1;
    #1 check_eq("rst_mid_out", 64'(outs), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_no_done", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt; o0 = ovf_cnt;
    send_frame(50, 50, 8'h66);
    wait_end(d0, o0);
    check_eq("after_rst_done", 64'(done_cnt - d0), 64'd1);
    check_eq("after_rst_sb_left", 64'(sb.size()), 64'd0);

    // Slave ready high while the master is idle: nothing may complete
    c0 = rd_cnt + wr_cnt;
    force_rdy = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("idle_no_cpl", 64'(rd_cnt + wr_cnt - c0), 64'd0);
    check_eq("idle_no_valid", 64'(m_valid), 64'd0);
    force_rdy = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("gap_after_cpl", 64'(gap_viol), 64'd0);
    check_eq("access_len", 64'(len_viol), 64'd0);
    check_eq("bus_stable", 64'(stab_viol), 64'd0);
    check_eq("read_addr", 64'(rdaddr_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
